// File: rtl/lsu_rd_master.sv
// Load-side read initiator: one aligned AR/R transaction per load request,
// returning the selected byte/half/word with sign or zero extension.
module lsu_rd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] size;
    logic       uns;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              bad_req;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ext_v;

  // Alignment is judged on the request as it is accepted, so the error
  // result is ready one cycle after acceptance without touching the bus.
  always_comb begin
    bad_req = 1'b0;
    case (req_size_i)
      2'd1:    bad_req = req_addr_i[0];
      2'd2:    bad_req = |req_addr_i[1:0];
      2'd3:    bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  always_comb begin
    byte_v = 8'h00;
    case (req_q.lane)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = req_q.lane[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (req_q.size)
      2'd0:    ext_v = {{(DATA_W-8){~req_q.uns & byte_v[7]}}, byte_v};
      2'd1:    ext_v = {{(DATA_W-16){~req_q.uns & half_v[15]}}, half_v};
      default: ext_v = rdata_i;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid_i) state_nxt = bad_req ? DONE : ADDR;
      ADDR: if (arready_i)   state_nxt = DATA;
      DATA: if (rvalid_i)    state_nxt = DONE;
      DONE: if (resp_ready_i) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      req_q    <= '0;
      araddr_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid_i) begin
          req_q    <= '{lane: req_addr_i[1:0], size: req_size_i, uns: req_unsigned_i};
          araddr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
          if (bad_req) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        DATA: if (rvalid_i) begin
          if (|rresp_i) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            data_q <= ext_v;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign arvalid_o    = (state == ADDR);
  assign rready_o     = (state == DATA);
  assign resp_valid_o = (state == DONE);
  assign busy_o       = (state != IDLE);
  assign araddr_o     = araddr_q;
  assign resp_data_o  = data_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_rd_master.sv
// Scoreboarded bench: directed loads push expected results, a monitor pops
// and compares at each result handshake; a small responder models AR/R waits.
module tb_lsu_rd_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i, rresp_i;
  logic        rvalid_i, rready_o;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_err_o, busy_o;

  lsu_rd_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          ar_wait = 0, r_wait = 0, a_cnt = 0, r_cnt = 0;
  logic [31:0] rd_word = 0, rd_resp = 0;
  logic [31:0] exp_araddr = 0;
  int          ar_hs = 0;
  logic        ar_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Result monitor / scoreboard
  always @(negedge clk) begin
    if (rst && resp_valid_o && resp_ready_i) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got data 0x%08h with no pending load", resp_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", resp_data_o, e.data);
        chk("resp_err", {31'b0, resp_err_o}, {31'b0, e.err});
      end
    end
    if (rst && arvalid_o) chk("araddr_stable", araddr_o, exp_araddr);
  end

  // Handshake bookkeeping on the edge the DUT sees
  always @(posedge clk) begin
    if (arvalid_o && arready_i) ar_hs++;
    if (arvalid_o) ar_seen = 1'b1;
  end

  // Responder: ar_wait / r_wait low cycles before each ready/valid
  initial begin
    arready_i = 0; rvalid_i = 0; rdata_i = 32'h0BAD_0BAD; rresp_i = 0;
    forever begin
      @(negedge clk);
      if (arvalid_o) begin
        arready_i = (a_cnt == ar_wait);
        a_cnt++;
      end else begin
        arready_i = 0; a_cnt = 0;
      end
      if (rready_o) begin
        rvalid_i = (r_cnt == r_wait);
        rdata_i  = rvalid_i ? rd_word : 32'h0BAD_0BAD;
        rresp_i  = rvalid_i ? rd_resp : 32'h0;
        r_cnt++;
      end else begin
        rvalid_i = 0; r_cnt = 0; rresp_i = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic u,
                       input logic push, input logic [31:0] ed, input logic ee);
    exp_t e;
    e.data = ed; e.err = ee;
    if (push) sb.push_back(e);
    exp_araddr = {a[31:2], 2'b00};
    @(posedge clk); #1;
    req_valid_i = 1; req_addr_i = a; req_size_i = s; req_unsigned_i = u;
    @(posedge clk); #1;
    req_valid_i = 0; req_addr_i = 32'h0; req_size_i = 2'd0; req_unsigned_i = 0;
  endtask

  // Cycles from acceptance edge until resp_valid_o is seen
  task automatic wait_resp(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (resp_valid_o) begin cyc = i; break; end
    end
    if (cyc == 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid expected within %0d cycles", max);
    end
  endtask

  task automatic load(input string name, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] ed, input logic ee, input int lat);
    int cyc;
    int hs0;
    hs0 = ar_hs;
    ar_seen = 0;
    issue(a, s, u, 1'b1, ed, ee);
    wait_resp(60, cyc);
    if (lat > 0) chk({name, "_latency"}, cyc, lat);
    @(posedge clk); #1;
    chk({name, "_ar_handshakes"}, ar_hs - hs0, ee && lat == 1 ? 0 : 1);
    if (lat == 1) chk({name, "_no_arvalid"}, {31'b0, ar_seen}, 32'h0);
  endtask

  initial begin
    int cyc;
    rst = 0; resp_ready_i = 1;
    req_valid_i = 0; req_addr_i = 0; req_size_i = 0; req_unsigned_i = 0;
    // Reset with random request inputs
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      req_valid_i = 1'($urandom); req_addr_i = $urandom;
      req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_outs", {27'b0, req_ready_o, arvalid_o, rready_o, resp_valid_o, busy_o}, 32'h10);
    chk("rst_araddr", araddr_o, 32'h0);
    chk("rst_data", resp_data_o, 32'h0);
    chk("rst_err", {31'b0, resp_err_o}, 32'h0);
    req_valid_i = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("idle_stable", {27'b0, req_ready_o, arvalid_o, rready_o, resp_valid_o, busy_o}, 32'h10);

    // Word load with 2 AR waits and 3 R waits
    ar_wait = 2; r_wait = 3; rd_word = 32'hDEAD_BEEF; rd_resp = 0;
    load("word_wait", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 8);

    // Zero-wait byte/half loads
    ar_wait = 0; r_wait = 0; rd_word = 32'h80FF_1234;
    load("byte_s", 32'h8000_0003, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 3);
    load("byte_u", 32'h8000_0003, 2'd0, 1'b1, 32'h0000_0080, 1'b0, 3);
    load("half_s", 32'h8000_0002, 2'd1, 1'b0, 32'hFFFF_80FF, 1'b0, 3);
    load("half_u0", 32'h8000_0000, 2'd1, 1'b1, 32'h0000_1234, 1'b0, 3);
    load("byte_s1", 32'h8000_0001, 2'd0, 1'b0, 32'h0000_0012, 1'b0, 3);

    // Alignment / illegal-size errors never reach the bus
    load("mis_half", 32'h8000_0001, 2'd1, 1'b0, 32'h0, 1'b1, 1);
    load("size3", 32'h8000_0000, 2'd3, 1'b0, 32'h0, 1'b1, 1);
    load("mis_word", 32'h8000_0002, 2'd2, 1'b1, 32'h0, 1'b1, 1);

    // Bus error response
    rd_word = 32'h1234_5678; rd_resp = 32'h1;
    load("bus_err", 32'h8000_0008, 2'd2, 1'b0, 32'h0, 1'b1, 3);
    rd_resp = 0;

    // Result back-pressure
    resp_ready_i = 0;
    rd_word = 32'hCAFE_F00D;
    issue(32'h8000_0010, 2'd2, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    wait_resp(20, cyc);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, resp_valid_o}, 32'h1);
      chk("bp_data", resp_data_o, 32'hCAFE_F00D);
      chk("bp_ready_low", {30'b0, req_ready_o, busy_o}, 32'h1);
      @(negedge clk);
    end
    resp_ready_i = 1;
    @(posedge clk); #1;
    chk("bp_release", {31'b0, req_ready_o}, 32'h1);

    // Reset while waiting for read data
    r_wait = 10;
    issue(32'h8000_0020, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10 && !rready_o; i++) @(negedge clk);
    chk("in_data", {31'b0, rready_o}, 32'h1);
    rst = 0;
    @(negedge clk);
    chk("abort_outs", {27'b0, req_ready_o, arvalid_o, rready_o, resp_valid_o, busy_o}, 32'h10);
    rst = 1; r_wait = 0;
    repeat (4) @(negedge clk);
    chk("abort_no_resp", {31'b0, resp_valid_o}, 32'h0);

    // Normal operation resumes after abort
    rd_word = 32'h0000_7F00;
    load("post_abort", 32'h8000_0001, 2'd0, 1'b0, 32'h0000_007F, 1'b0, 3);

    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end
endmodule
